// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst initiator: one command becomes a classic single beat or an
// incrementing (linear / wrapped) registered-feedback burst of up to 16 beats.
module wb_b3_burst_master #(
   parameter int aw        = 32,
   parameter int dw        = 32,
   parameter int max_len_w = 5
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [aw-1:0]        cmd_adr_i,
   input  logic [max_len_w-1:0] cmd_len_i,
   input  logic [1:0]           cmd_bte_i,
   input  logic [3:0]           cmd_sel_i,
   input  logic [dw-1:0]        wdat_i,
   input  logic                 wdat_valid_i,
   output logic                 wdat_ready_o,
   output logic [dw-1:0]        rdat_o,
   output logic                 rdat_valid_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [aw-1:0]        wb_adr_o,
   output logic [dw-1:0]        wb_dat_o,
   output logic [3:0]           wb_sel_o,
   output logic                 wb_we_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic [2:0]           wb_cti_o,
   output logic [1:0]           wb_bte_o,
   input  logic [dw-1:0]        wb_dat_i,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i,
   input  logic                 wb_rty_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          we_q, we_d;
   logic [4:0]    len_q, len_d;
   logic [1:0]    bte_q, bte_d;
   logic [aw-1:0] adr_q, adr_d;
   logic [3:0]    sel_q, sel_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [dw-1:0] rdat_q, rdat_d;
   logic          rdat_valid_q, rdat_valid_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          in_xfer, stb, last_beat, beat_ok, abort;
   logic [4:0]    len_norm;
   logic [aw-3:0] word_idx, word_inc, word_nxt;
   logic [1:0]    unused_adr_lsb;

   assign unused_adr_lsb = cmd_adr_i[1:0];

   // Out-of-range lengths: 0 behaves as a single beat, anything above 16 is clamped.
   always_comb begin
      len_norm = 5'(cmd_len_i);
      if (cmd_len_i == '0)
         len_norm = 5'd1;
      else if (cmd_len_i > max_len_w'(16))
         len_norm = 5'd16;
   end

   assign in_xfer   = (state_q == ST_XFER);
   assign stb       = in_xfer & (we_q ? wdat_valid_i : 1'b1);
   assign last_beat = (cnt_q == len_q - 5'd1);
   assign beat_ok   = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;
   assign abort     = stb & (wb_err_i | wb_rty_i);

   // Wrapped bursts only advance the low word-index bits; upper bits stay put.
   assign word_idx = adr_q[aw-1:2];
   assign word_inc = word_idx + 1'b1;
   always_comb begin
      case (bte_q)
         2'b01:   word_nxt = {word_idx[aw-3:2], word_inc[1:0]};
         2'b10:   word_nxt = {word_idx[aw-3:3], word_inc[2:0]};
         2'b11:   word_nxt = {word_idx[aw-3:4], word_inc[3:0]};
         default: word_nxt = word_inc;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      len_d        = len_q;
      bte_d        = bte_q;
      adr_d        = adr_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      rdat_d       = rdat_q;
      rdat_valid_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               state_d = ST_XFER;
               we_d    = cmd_we_i;
               len_d   = len_norm;
               bte_d   = cmd_bte_i;
               adr_d   = {cmd_adr_i[aw-1:2], 2'b00};
               sel_d   = (len_norm == 5'd1) ? cmd_sel_i : 4'hf;
               cnt_d   = 5'd0;
            end
         end
         ST_XFER: begin
            if (abort) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (beat_ok) begin
               cnt_d = cnt_q + 5'd1;
               if (!we_q) begin
                  rdat_d       = wb_dat_i;
                  rdat_valid_d = 1'b1;
               end
               if (last_beat) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  adr_d = {word_nxt, 2'b00};
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         len_q        <= 5'd1;
         bte_q        <= 2'b00;
         adr_q        <= '0;
         sel_q        <= 4'hf;
         cnt_q        <= 5'd0;
         rdat_q       <= '0;
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         len_q        <= len_d;
         bte_q        <= bte_d;
         adr_q        <= adr_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         rdat_q       <= rdat_d;
         rdat_valid_q <= rdat_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign wdat_ready_o = beat_ok & we_q;
   assign rdat_o       = rdat_q;
   assign rdat_valid_o = rdat_valid_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = wdat_i;
   assign wb_sel_o     = sel_q;
   assign wb_we_o      = we_q & in_xfer;
   assign wb_cyc_o     = in_xfer;
   assign wb_stb_o     = stb;
   assign wb_bte_o     = bte_q;
   assign wb_cti_o     = !in_xfer          ? 3'b000 :
                         (len_q == 5'd1)   ? 3'b000 :
                         last_beat         ? 3'b111 : 3'b010;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed bench for wb_b3_burst_master: a slave model answers the bus, and a
// monitor pops expected bus beats, read data and completions from queues.
module tb_wb_b3_burst_master;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [4:0]  cmd_len;
   logic [1:0]  cmd_bte;
   logic [3:0]  cmd_sel;
   logic [31:0] wdat;
   logic        wdat_valid, wdat_ready;
   logic [31:0] rdat;
   logic        rdat_valid, done, err;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        ack, serr, srty;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int wready_cnt = 0;
   int n_done = 0;

   // slave configuration and state
   int slave_wait = 0;
   int err_beat = 99;
   int err_kind = 0;
   int wait_cnt = 0;
   int slave_beat = 0;

   logic [71:0] exp_bus_q[$];
   logic [31:0] exp_rd_q[$];
   logic [0:0]  exp_done_q[$];

   wb_b3_burst_master #(.aw(32), .dw(32), .max_len_w(5)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte), .cmd_sel_i(cmd_sel),
      .wdat_i(wdat), .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready),
      .rdat_o(rdat), .rdat_valid_o(rdat_valid), .done_o(done), .err_o(err),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(ack), .wb_err_i(serr), .wb_rty_i(srty)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign wb_dat_i = 32'hA5A5_0000 ^ wb_adr_o;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event missing or timed out", name);
   endtask

   function automatic logic [71:0] bus(input logic we, input logic [2:0] cti, input logic [3:0] sel,
                                       input logic [31:0] adr, input logic [31:0] dat);
      return {we, cti, sel, adr, dat};
   endfunction

   // slave model: decides ack/err/rty for the coming edge
   always @(negedge clk) begin
      ack = 1'b0; serr = 1'b0; srty = 1'b0;
      if (!rst_n || !wb_cyc_o) begin
         wait_cnt = 0;
         slave_beat = 0;
      end else if (wb_stb_o) begin
         if (wait_cnt < slave_wait) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            if (slave_beat == err_beat) begin
               if (err_kind == 0) serr = 1'b1;
               else srty = 1'b1;
            end else begin
               ack = 1'b1;
            end
            slave_beat++;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (wb_cyc_o && wb_stb_o && ack) begin
            if (exp_bus_q.size() == 0) fail_now("bus_unexpected_beat");
            else check("bus_beat", {wb_we_o, wb_cti_o, wb_sel_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0},
                       exp_bus_q.pop_front());
         end
         if (rdat_valid) begin
            if (exp_rd_q.size() == 0) fail_now("rdat_unexpected");
            else check("rdat", 72'(rdat), 72'(exp_rd_q.pop_front()));
         end
         if (done) begin
            if (exp_done_q.size() == 0) fail_now("done_unexpected");
            else check("done_err", 72'(err), 72'(exp_done_q.pop_front()));
            check("done_bus_idle", {70'h0, wb_cyc_o, wb_stb_o}, 72'h0);
            done_cnt++;
         end
         if (wdat_ready) wready_cnt++;
      end
   end

   // driver tasks
   task automatic slave_setup(input int w, input int eb, input int kind);
      slave_wait = w;
      err_beat = eb;
      err_kind = kind;
   endtask

   task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [4:0] len,
                           input logic [1:0] bte, input logic [3:0] sel);
      int g;
      cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte; cmd_sel = sel;
      cmd_valid = 1'b1;
      g = 0;
      do begin
         @(negedge clk); #2;
         g++;
      end while (!cmd_ready && g < 50);
      if (!cmd_ready) fail_now("cmd_accept");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic write_stream(input int n, input logic [31:0] base, input int gap_beat,
                               input logic [31:0] gap_adr);
      int g;
      for (int i = 0; i < n; i++) begin
         if (i == gap_beat) begin
            wdat_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk); #2;
               check("gap_cyc_stb_adr", {38'h0, wb_cyc_o, wb_stb_o, wb_adr_o}, {38'h0, 1'b1, 1'b0, gap_adr});
               @(posedge clk); #1;
            end
         end
         wdat_valid = 1'b1;
         wdat = base + 32'(i);
         g = 0;
         do begin
            @(negedge clk); #2;
            g++;
         end while (!wdat_ready && g < 50);
         if (!wdat_ready) begin
            fail_now("wdat_ready");
            break;
         end
         @(posedge clk); #1;
      end
      wdat_valid = 1'b0;
   endtask

   task automatic wait_done();
      int g;
      n_done++;
      g = 0;
      while (done_cnt < n_done && g < 300) begin
         @(posedge clk);
         g++;
      end
      if (done_cnt < n_done) fail_now("wait_done");
      #1;
   endtask

   task automatic check_drained(input string name);
      check(name, {48'h0, 8'(exp_bus_q.size()), 8'(exp_rd_q.size()), 8'(exp_done_q.size())}, 72'h0);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {23'h0, wb_cyc_o, wb_stb_o, wb_we_o, done, err, rdat_valid, cmd_ready,
                   wb_cti_o, wb_bte_o, wb_sel_o, wb_adr_o},
                  {23'h0, 7'b0000001, 3'b000, 2'b00, 4'hf, 32'h0});
   endtask

   initial begin
      int base_rdy, g;
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_bte = '0; cmd_sel = '0;
      wdat = '0; wdat_valid = 1'b0;
      ack = 1'b0; serr = 1'b0; srty = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single read, slave waits two cycles
      slave_setup(2, 99, 0);
      exp_bus_q.push_back(bus(1'b0, 3'b000, 4'h3, 32'h104, 32'h0));
      exp_rd_q.push_back(32'hA5A5_0104);
      exp_done_q.push_back(1'b0);
      send_cmd(1'b0, 32'h104, 5'd1, 2'b00, 4'h3);
      wait_done();
      check_drained("drain_single_read");

      // linear write burst, zero wait
      slave_setup(0, 99, 0);
      base_rdy = wready_cnt;
      exp_bus_q.push_back(bus(1'b1, 3'b010, 4'hf, 32'h40, 32'h1));
      exp_bus_q.push_back(bus(1'b1, 3'b010, 4'hf, 32'h44, 32'h2));
      exp_bus_q.push_back(bus(1'b1, 3'b010, 4'hf, 32'h48, 32'h3));
      exp_bus_q.push_back(bus(1'b1, 3'b111, 4'hf, 32'h4C, 32'h4));
      exp_done_q.push_back(1'b0);
      send_cmd(1'b1, 32'h40, 5'd4, 2'b00, 4'h1);
      write_stream(4, 32'h1, -1, 32'h0);
      wait_done();
      check("wdat_ready_count", 72'(wready_cnt - base_rdy), 72'd4);
      check_drained("drain_write_linear");

      // wrap8 read starting at 0x1C, one wait state per beat
      slave_setup(1, 99, 0);
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h1C, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h00, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h04, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h08, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h0C, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h10, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h14, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b111, 4'hf, 32'h18, 32'h0));
      exp_rd_q.push_back(32'hA5A5_001C); exp_rd_q.push_back(32'hA5A5_0000);
      exp_rd_q.push_back(32'hA5A5_0004); exp_rd_q.push_back(32'hA5A5_0008);
      exp_rd_q.push_back(32'hA5A5_000C); exp_rd_q.push_back(32'hA5A5_0010);
      exp_rd_q.push_back(32'hA5A5_0014); exp_rd_q.push_back(32'hA5A5_0018);
      exp_done_q.push_back(1'b0);
      send_cmd(1'b0, 32'h1C, 5'd8, 2'b10, 4'hf);
      wait_done();
      check_drained("drain_read_wrap8");

      // write with a three-cycle data gap before beat 3
      slave_setup(0, 99, 0);
      exp_bus_q.push_back(bus(1'b1, 3'b010, 4'hf, 32'h80, 32'h11));
      exp_bus_q.push_back(bus(1'b1, 3'b010, 4'hf, 32'h84, 32'h12));
      exp_bus_q.push_back(bus(1'b1, 3'b010, 4'hf, 32'h88, 32'h13));
      exp_bus_q.push_back(bus(1'b1, 3'b111, 4'hf, 32'h8C, 32'h14));
      exp_done_q.push_back(1'b0);
      send_cmd(1'b1, 32'h80, 5'd4, 2'b00, 4'hf);
      write_stream(4, 32'h11, 2, 32'h88);
      wait_done();
      check_drained("drain_write_gap");

      // read aborted by err on beat 2
      slave_setup(0, 1, 0);
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h200, 32'h0));
      exp_rd_q.push_back(32'hA5A5_0200);
      exp_done_q.push_back(1'b1);
      send_cmd(1'b0, 32'h200, 5'd4, 2'b00, 4'hf);
      wait_done();
      check_drained("drain_read_err");

      // read aborted by rty on the first beat
      slave_setup(0, 0, 1);
      exp_done_q.push_back(1'b1);
      send_cmd(1'b0, 32'h240, 5'd2, 2'b00, 4'hf);
      wait_done();
      check_drained("drain_read_rty");

      // len=0 behaves as a single classic beat
      slave_setup(0, 99, 0);
      exp_bus_q.push_back(bus(1'b0, 3'b000, 4'hc, 32'h50, 32'h0));
      exp_rd_q.push_back(32'hA5A5_0050);
      exp_done_q.push_back(1'b0);
      send_cmd(1'b0, 32'h52, 5'd0, 2'b00, 4'hc);
      wait_done();
      check_drained("drain_len0");

      // reset while beat 3 of an 8-beat read is waiting
      slave_setup(1, 99, 0);
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h300, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h304, 32'h0));
      exp_rd_q.push_back(32'hA5A5_0300);
      exp_rd_q.push_back(32'hA5A5_0304);
      send_cmd(1'b0, 32'h300, 5'd8, 2'b00, 4'hf);
      g = 0;
      do begin
         @(negedge clk); #2;
         g++;
      end while (!(slave_beat == 2 && wb_stb_o && !ack) && g < 100);
      if (g >= 100) fail_now("reach_beat3");
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset_midburst");
      check_drained("drain_before_reset");
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      slave_setup(0, 99, 0);
      exp_bus_q.push_back(bus(1'b0, 3'b010, 4'hf, 32'h10, 32'h0));
      exp_bus_q.push_back(bus(1'b0, 3'b111, 4'hf, 32'h14, 32'h0));
      exp_rd_q.push_back(32'hA5A5_0010);
      exp_rd_q.push_back(32'hA5A5_0014);
      exp_done_q.push_back(1'b0);
      send_cmd(1'b0, 32'h10, 5'd2, 2'b00, 4'hf);
      wait_done();
      check_drained("drain_after_reset");

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      fail_now("global_watchdog");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_b3_burst_master.md
Name: wb_b3_burst_master

Overview:
Wishbone B3 initiator that turns one command (address, length, direction, burst type) into a registered-feedback burst on the bus. It drives incrementing bursts (cti 3'b010) with linear or wrapped (bte) addressing, and uses a classic cycle for single beats. Write data streams in and read data streams out through valid/ready ports. It is the bus-master counterpart of the system's Wishbone B3 RAM responders and sits between a DMA/cache-fill client and the bus arbiter.

Parameters:
aw, 32, byte address width
dw, 32, data width (fixed 32; sel is 4 bits)
max_len_w, 5, width of cmd_len_i; legal lengths are 1..16

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  aw  start byte address; bits [1:0] are ignored
cmd_len_i  in  max_len_w  beat count, 1..16
cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16
cmd_sel_i  in  4  byte select, used only when len=1
wdat_i  in  dw  write data
wdat_valid_i  in  1  write data available
wdat_ready_o  out  1  write beat consumed
rdat_o  out  dw  read data
rdat_valid_o  out  1  read beat valid; no backpressure
done_o  out  1  one-cycle pulse when the command completes
err_o  out  1  valid with done_o: the burst was terminated by err or rty
wb_adr_o  out  aw  bus address
wb_dat_o  out  dw  bus write data
wb_sel_o  out  4  byte select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type
wb_dat_i  in  dw  bus read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
wb_rty_i  in  1  retry

Behaviour:
- Reset, asynchronous: state=IDLE. cyc, stb, we, done_o, err_o, rdat_valid_o are 0. adr=0, cti=3'b000, bte=2'b00, sel=4'hf, beat counter=0.
- cmd_ready_o = (state==IDLE). On acceptance, latch we, len, bte and adr with [1:0] forced to 00. Go to XFER next cycle with cyc=1.
- XFER:
  - Read: stb=1.
  - Write: stb=wdat_valid_i. cyc stays high while stb is low (wait states). wb_dat_o=wdat_i combinationally; wdat_ready_o=wb_ack_i&stb&we.
- cti:
  - len=1: 3'b000.
  - Otherwise 3'b010 on every beat except the last, which is 3'b111.
  - wb_bte_o is the latched bte throughout.
- sel: cmd_sel_i when len=1, otherwise 4'hf.
- A beat completes on a clock edge where stb&ack is high.
  - Read: rdat_o is registered from wb_dat_i, and rdat_valid_o is high for one cycle in the cycle after the ack.
  - The counter increments. The address advances by 4 (word index +1). For bte 01/10/11 only word-index bits [1:0], [2:0] or [3:0] increment, with wrap; upper bits are held. Linear carries through all bits.
- Last beat acked: cyc and stb drop at the same edge. done_o pulses the next cycle with err_o=0. Return to IDLE; the next command can be accepted at the earliest in the cycle after done_o.
- err_i or rty_i with stb high (takes priority over ack in the same cycle): abort. cyc and stb drop at that edge and no data is consumed or produced for that beat. done_o and err_o pulse together, then IDLE. No automatic retry.
- Unlisted len values: len=0 is treated as 1; len>16 is clamped to 16.
- wrap bte with len smaller than the wrap size is legal: it wraps within the boundary and stops after len beats.
- Asserting reset mid-burst drops cyc and stb immediately (asynchronously). No done_o is produced.

Test Plan:
- Read, len=1, adr=0x104, slave acks 2 cycles later → cti=000, sel=cmd_sel, one rdat_valid pulse with the slave data, done_o=1, err_o=0, cyc low after the ack.
- Write, len=4, bte=00, adr=0x40, data 1..4, zero-wait ack → adr sequence 0x40/44/48/4C, cti 010,010,010,111, four wdat_ready pulses, done_o.
- Read, len=8, bte=10, adr=0x1C → adr 0x1C,0x00,0x04,...,0x18, i.e. wrap within 0x00..0x1F; 8 rdat pulses in order.
- Write, len=4 with wdat_valid low for 3 cycles before beat 3 → stb low and cyc high during the gap, adr held at beat 3, the burst resumes and completes correctly.
- Read, len=4, err_i on beat 2 → exactly 1 rdat pulse, cyc drops at the err edge, done_o=err_o=1.
- Reset asserted during beat 3 of an 8-beat burst → outputs go to reset values without waiting for a clock edge; a new command after reset starts cleanly with cti=010.
